// File: rtl/bpu_gshare.sv
// Gshare branch predictor: BTB (tag/target/type), PC^GHR indexed PHT and a circular RAS,
// with per-branch GHR/RAS-pointer checkpoints and a redirect-hold FSM.
module bpu_gshare #(
  parameter int unsigned BTB_DEPTH = 1024,
  parameter int unsigned PHT_DEPTH = 1024,
  parameter int unsigned GHR_W     = 8,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ex_flush,
  input  logic                         correct_finish,
  input  logic                         pred_valid,
  input  logic [31:0]                  pred_pc,
  input  logic [2:0]                   pred_br_type,
  output logic                         pred_hit,
  output logic                         pred_taken,
  output logic [31:0]                  pred_target,
  output logic [GHR_W-1:0]             pred_ghr,
  output logic [$clog2(RAS_DEPTH)-1:0] pred_ras_ptr,
  input  logic                         ver_valid,
  input  logic [31:0]                  ver_pc,
  input  logic [2:0]                   ver_br_type,
  input  logic                         ver_taken,
  input  logic [31:0]                  ver_target,
  input  logic                         ver_mispredict,
  input  logic [GHR_W-1:0]             ver_ghr,
  input  logic [$clog2(RAS_DEPTH)-1:0] ver_ras_ptr,
  output logic                         flush,
  output logic                         is_correction,
  output logic [31:0]                  correct_target
);
  localparam int unsigned IDX_W  = $clog2(BTB_DEPTH);
  localparam int unsigned PIDX_W = $clog2(PHT_DEPTH);
  localparam int unsigned RP_W   = $clog2(RAS_DEPTH);
  localparam int unsigned TAG_W  = 32 - IDX_W - 2;

  localparam logic [2:0] B_IS_BRA  = 3'd1;
  localparam logic [2:0] B_IS_J    = 3'd2;
  localparam logic [2:0] B_IS_CALL = 3'd3;
  localparam logic [2:0] B_IS_RET  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

  typedef enum logic {S_IDLE, S_CORR} state_t;

  logic [BTB_DEPTH-1:0] btb_valid_q;
  logic [TAG_W-1:0]     btb_tag_q  [BTB_DEPTH];
  logic [31:0]          btb_tgt_q  [BTB_DEPTH];
  logic [2:0]           btb_type_q [BTB_DEPTH];
  logic [CNT_W-1:0]     pht_q      [PHT_DEPTH];
  logic [31:0]          ras_q      [RAS_DEPTH];

  state_t            state_q;
  logic [GHR_W-1:0]  ghr_q;
  logic [RP_W-1:0]   ras_ptr_q;

  logic [IDX_W-1:0]  idx, vidx;
  logic [TAG_W-1:0]  tag, vtag;
  logic [PIDX_W-1:0] pidx, vpidx;
  logic [CNT_W-1:0]  pht_cnt, cnt_old, cnt_new;
  logic [31:0]       pc_plus8, ras_top;
  logic              act, mispredict, spec_upd, ver_train, ver_hit;

  // Lookup side
  assign idx      = pred_pc[IDX_W+1:2];
  assign tag      = pred_pc[31:IDX_W+2];
  assign pidx     = pred_pc[PIDX_W+1:2] ^ PIDX_W'(ghr_q);
  assign pht_cnt  = pht_q[pidx];
  assign pc_plus8 = pred_pc + 32'd8;
  assign ras_top  = ras_q[ras_ptr_q - RP_W'(1)];
  assign pred_hit = btb_valid_q[idx] && (btb_tag_q[idx] == tag);
  assign pred_ghr = ghr_q;

  assign act        = pred_valid && (pred_br_type != 3'd0) && (state_q == S_IDLE);
  assign mispredict = ver_valid && ver_mispredict;
  assign spec_upd   = act && !mispredict && !ex_flush;
  assign flush      = mispredict;
  assign is_correction = (state_q == S_CORR);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus8;
    if (pred_hit) begin
      case (pred_br_type)
        B_IS_CALL, B_IS_J: begin
          pred_taken  = 1'b1;
          pred_target = btb_tgt_q[idx];
        end
        B_IS_RET: begin
          pred_taken  = 1'b1;
          pred_target = ras_top;
        end
        B_IS_BRA: begin
          pred_taken = pht_cnt[CNT_W-1];
          if (pht_cnt[CNT_W-1]) pred_target = btb_tgt_q[idx];
        end
        default: ;
      endcase
    end
  end

  // Checkpoint reflects this branch's own push/pop
  always_comb begin
    pred_ras_ptr = ras_ptr_q;
    if (pred_br_type == B_IS_CALL)     pred_ras_ptr = ras_ptr_q + RP_W'(1);
    else if (pred_br_type == B_IS_RET) pred_ras_ptr = ras_ptr_q - RP_W'(1);
  end

  // Training side: a counter only counts as existing if its BTB entry already held this branch
  assign ver_train = ver_valid && (ver_br_type != 3'd0);
  assign vidx      = ver_pc[IDX_W+1:2];
  assign vtag      = ver_pc[31:IDX_W+2];
  assign vpidx     = ver_pc[PIDX_W+1:2] ^ PIDX_W'(ver_ghr);
  assign cnt_old   = pht_q[vpidx];
  assign ver_hit   = btb_valid_q[vidx] && (btb_tag_q[vidx] == vtag) &&
                     (btb_type_q[vidx] == B_IS_BRA);

  always_comb begin
    cnt_new = ver_taken ? CNT_WT : CNT_WNT;
    if (ver_hit) begin
      if (ver_taken) cnt_new = (cnt_old == CNT_MAX) ? cnt_old : cnt_old + CNT_W'(1);
      else           cnt_new = (cnt_old == '0) ? cnt_old : cnt_old - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          btb_valid_q <= '0;
    else if (ver_train) btb_valid_q[vidx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset && ver_train) begin
      btb_tag_q[vidx]  <= vtag;
      btb_tgt_q[vidx]  <= ver_target;
      btb_type_q[vidx] <= ver_br_type;
      if (ver_br_type == B_IS_BRA) pht_q[vpidx] <= cnt_new;
    end
    if (!reset && spec_upd && (pred_br_type == B_IS_CALL)) ras_q[ras_ptr_q] <= pc_plus8;
  end

  // Redirect FSM plus speculative GHR / RAS pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      correct_target <= '0;
      ghr_q          <= '0;
      ras_ptr_q      <= '0;
    end else if (ex_flush) begin
      state_q        <= S_IDLE;
      correct_target <= '0;
    end else if ((state_q == S_CORR) && correct_finish) begin
      state_q        <= S_IDLE;
      correct_target <= '0;
    end else if (mispredict) begin
      if (state_q == S_IDLE) begin
        state_q        <= S_CORR;
        correct_target <= ver_taken ? ver_target : ver_pc + 32'd8;
        ghr_q          <= (ver_br_type == B_IS_BRA) ? {ver_ghr[GHR_W-2:0], ver_taken} : ver_ghr;
        ras_ptr_q      <= ver_ras_ptr;
      end
    end else if (act) begin
      if (pred_br_type == B_IS_BRA) ghr_q <= {ghr_q[GHR_W-2:0], pred_taken};
      ras_ptr_q <= pred_ras_ptr;
    end
  end
endmodule

// File: tb/tb_bpu_gshare.sv
// Scoreboard bench for bpu_gshare: stimulus queues expected lookup/flush/state responses,
// a negedge monitor pops and compares them.
module tb_bpu_gshare;
  localparam logic [2:0] BRA = 3'd1, JMP = 3'd2, CALL = 3'd3, RET = 3'd4;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [7:0]  ghr;
    logic [2:0]  ptr;
  } lk_t;

  typedef struct packed {
    logic        corr;
    logic [31:0] ct;
    logic        flush;
  } st_t;

  logic        clk = 1'b0;
  logic        reset, ex_flush, correct_finish, pred_valid;
  logic [31:0] pred_pc;
  logic [2:0]  pred_br_type;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_ghr;
  logic [2:0]  pred_ras_ptr;
  logic        ver_valid, ver_taken, ver_mispredict;
  logic [31:0] ver_pc, ver_target;
  logic [2:0]  ver_br_type;
  logic [7:0]  ver_ghr;
  logic [2:0]  ver_ras_ptr;
  logic        flush, is_correction;
  logic [31:0] correct_target;

  logic chk_st = 1'b0;
  logic done   = 1'b0;
  lk_t  lk_q[$];
  logic vr_q[$];
  st_t  st_q[$];
  int   checks = 0;
  int   errors = 0;

  bpu_gshare dut (
    .clk(clk), .reset(reset), .ex_flush(ex_flush), .correct_finish(correct_finish),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_br_type(pred_br_type),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_ghr(pred_ghr), .pred_ras_ptr(pred_ras_ptr),
    .ver_valid(ver_valid), .ver_pc(ver_pc), .ver_br_type(ver_br_type),
    .ver_taken(ver_taken), .ver_target(ver_target), .ver_mispredict(ver_mispredict),
    .ver_ghr(ver_ghr), .ver_ras_ptr(ver_ras_ptr),
    .flush(flush), .is_correction(is_correction), .correct_target(correct_target)
  );

  always #5 clk = ~clk;

  function automatic lk_t mk(input logic h, input logic t, input logic [31:0] tg,
                             input logic [7:0] g, input logic [2:0] p);
    mk = '{hit: h, taken: t, target: tg, ghr: g, ptr: p};
  endfunction

  task automatic begin_cyc();
    @(posedge clk);
    #1;
    reset = 1'b0; ex_flush = 1'b0; correct_finish = 1'b0;
    pred_valid = 1'b0; ver_valid = 1'b0; ver_mispredict = 1'b0; chk_st = 1'b0;
  endtask

  task automatic end_cyc(input logic peek);
    @(negedge clk);
    #1;
    if (peek) pred_valid = 1'b0;
    chk_st = 1'b0;
  endtask

  task automatic set_pred(input logic [31:0] pc, input logic [2:0] typ, input lk_t e);
    pred_valid = 1'b1; pred_pc = pc; pred_br_type = typ;
    lk_q.push_back(e);
  endtask

  task automatic set_ver(input logic [31:0] pc, input logic [2:0] typ, input logic tk,
                         input logic [31:0] tg, input logic mp, input logic [7:0] g,
                         input logic [2:0] p, input logic exp_flush);
    ver_valid = 1'b1; ver_pc = pc; ver_br_type = typ; ver_taken = tk; ver_target = tg;
    ver_mispredict = mp; ver_ghr = g; ver_ras_ptr = p;
    vr_q.push_back(exp_flush);
  endtask

  task automatic chk_state(input logic corr, input logic [31:0] ct, input logic fl);
    chk_st = 1'b1;
    st_q.push_back('{corr: corr, ct: ct, flush: fl});
  endtask

  task automatic peek(input logic [31:0] pc, input logic [2:0] typ, input lk_t e);
    begin_cyc(); set_pred(pc, typ, e); end_cyc(1'b1);
  endtask

  task automatic commit(input logic [31:0] pc, input logic [2:0] typ, input lk_t e);
    begin_cyc(); set_pred(pc, typ, e); end_cyc(1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [2:0] typ, input logic tk,
                       input logic [31:0] tg, input logic mp, input logic [7:0] g,
                       input logic [2:0] p, input logic exp_flush);
    begin_cyc(); set_ver(pc, typ, tk, tg, mp, g, p, exp_flush); end_cyc(1'b0);
  endtask

  task automatic state_cyc(input logic corr, input logic [31:0] ct);
    begin_cyc(); chk_state(corr, ct, 1'b0); end_cyc(1'b1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    lk_t le, la;
    st_t se, sa;
    logic fe;
    if (pred_valid) begin
      checks++;
      la = '{hit: pred_hit, taken: pred_taken, target: pred_target, ghr: pred_ghr, ptr: pred_ras_ptr};
      if (lk_q.size() == 0) begin
        errors++;
        $display("FAIL lookup_unexpected pc=%h", pred_pc);
      end else begin
        le = lk_q.pop_front();
        if (la !== le) begin
          errors++;
          $display("FAIL lookup pc=%h got hit=%0d tk=%0d tgt=%h ghr=%h ptr=%0d want hit=%0d tk=%0d tgt=%h ghr=%h ptr=%0d",
                   pred_pc, la.hit, la.taken, la.target, la.ghr, la.ptr,
                   le.hit, le.taken, le.target, le.ghr, le.ptr);
        end
      end
    end
    if (ver_valid) begin
      checks++;
      if (vr_q.size() == 0) begin
        errors++;
        $display("FAIL flush_unexpected pc=%h", ver_pc);
      end else begin
        fe = vr_q.pop_front();
        if (flush !== fe) begin
          errors++;
          $display("FAIL flush pc=%h got %0d want %0d", ver_pc, flush, fe);
        end
      end
    end
    if (chk_st) begin
      checks++;
      sa = '{corr: is_correction, ct: correct_target, flush: flush};
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL state_unexpected");
      end else begin
        se = st_q.pop_front();
        if (sa !== se) begin
          errors++;
          $display("FAIL state got corr=%0d ct=%h flush=%0d want corr=%0d ct=%h flush=%0d",
                   sa.corr, sa.ct, sa.flush, se.corr, se.ct, se.flush);
        end
      end
    end
    if (done) begin
      checks++;
      if (lk_q.size() != 0 || vr_q.size() != 0 || st_q.size() != 0) begin
        errors++;
        $display("FAIL leftover got lk=%0d vr=%0d st=%0d want 0 0 0",
                 lk_q.size(), vr_q.size(), st_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    reset = 1'b1; ex_flush = 1'b0; correct_finish = 1'b0;
    pred_valid = 1'b0; pred_pc = '0; pred_br_type = '0;
    ver_valid = 1'b0; ver_pc = '0; ver_br_type = '0; ver_taken = 1'b0; ver_target = '0;
    ver_mispredict = 1'b0; ver_ghr = '0; ver_ras_ptr = '0;
    repeat (3) @(posedge clk);

    // Reset state and cold miss
    state_cyc(1'b0, 32'h0);
    peek(32'hBFC00010, BRA, mk(1'b0, 1'b0, 32'hBFC00018, 8'h00, 3'd0));

    // Counter training: alloc->2, hit->3 (taken); then down to 0 and no wrap
    repeat (2) train(32'h80001000, BRA, 1'b1, 32'h80002000, 1'b0, 8'h00, 3'd0, 1'b0);
    peek(32'h80001000, BRA, mk(1'b1, 1'b1, 32'h80002000, 8'h00, 3'd0));
    repeat (4) train(32'h80001000, BRA, 1'b0, 32'h80002000, 1'b0, 8'h00, 3'd0, 1'b0);
    peek(32'h80001000, BRA, mk(1'b1, 1'b0, 32'h80001008, 8'h00, 3'd0));
    train(32'h80001000, BRA, 1'b1, 32'h80002000, 1'b0, 8'h00, 3'd0, 1'b0);
    peek(32'h80001000, BRA, mk(1'b1, 1'b0, 32'h80001008, 8'h00, 3'd0));

    // CALL / RET through the RAS
    train(32'h80000100, CALL, 1'b1, 32'h80005000, 1'b0, 8'h00, 3'd0, 1'b0);
    train(32'h80005040, RET,  1'b1, 32'h80000108, 1'b0, 8'h00, 3'd0, 1'b0);
    commit(32'h80000100, CALL, mk(1'b1, 1'b1, 32'h80005000, 8'h00, 3'd1));
    peek(32'h80005040, RET, mk(1'b1, 1'b1, 32'h80000108, 8'h00, 3'd0));
    for (int k = 0; k < 9; k++)
      commit(32'h80000200 + 32'(16 * k), CALL,
             mk(1'b0, 1'b0, 32'h80000208 + 32'(16 * k), 8'h00, 3'(2 + k)));
    peek(32'h80005040, RET, mk(1'b1, 1'b1, 32'h80000288, 8'h00, 3'd1));
    commit(32'h80005040, RET, mk(1'b1, 1'b1, 32'h80000288, 8'h00, 3'd1));
    peek(32'h80005040, RET, mk(1'b1, 1'b1, 32'h80000278, 8'h00, 3'd0));

    // Mispredict: redirect, GHR restore+shift, pointer restore, hold until ack
    train(32'h80001000, BRA, 1'b1, 32'h80003000, 1'b1, 8'h5A, 3'd1, 1'b1);
    state_cyc(1'b1, 32'h80003000);
    peek(32'hBFC00010, BRA, mk(1'b0, 1'b0, 32'hBFC00018, 8'hB5, 3'd1));
    commit(32'h80000100, CALL, mk(1'b1, 1'b1, 32'h80005000, 8'hB5, 3'd2));
    peek(32'h80005040, RET, mk(1'b1, 1'b1, 32'h80000278, 8'hB5, 3'd0));
    train(32'h80007020, JMP, 1'b1, 32'h80009000, 1'b1, 8'h00, 3'd3, 1'b1);
    state_cyc(1'b1, 32'h80003000);
    peek(32'hBFC00010, BRA, mk(1'b0, 1'b0, 32'hBFC00018, 8'hB5, 3'd1));
    begin_cyc(); correct_finish = 1'b1; chk_state(1'b1, 32'h80003000, 1'b0); end_cyc(1'b0);
    state_cyc(1'b0, 32'h0);

    // Mispredict coinciding with ex_flush
    begin_cyc(); ex_flush = 1'b1;
    set_ver(32'h80007020, JMP, 1'b1, 32'h80009000, 1'b1, 8'h11, 3'd5, 1'b1);
    end_cyc(1'b0);
    state_cyc(1'b0, 32'h0);
    peek(32'hBFC00010, BRA, mk(1'b0, 1'b0, 32'hBFC00018, 8'hB5, 3'd1));

    // Mispredict coinciding with a CALL lookup: restore wins, no push
    begin_cyc();
    set_ver(32'h80001000, BRA, 1'b0, 32'h80003000, 1'b1, 8'h03, 3'd6, 1'b1);
    set_pred(32'h80000100, CALL, mk(1'b1, 1'b1, 32'h80005000, 8'hB5, 3'd2));
    end_cyc(1'b0);
    state_cyc(1'b1, 32'h80001008);
    peek(32'h80005040, RET, mk(1'b1, 1'b1, 32'h80000248, 8'h06, 3'd5));
    begin_cyc(); correct_finish = 1'b1; end_cyc(1'b0);
    state_cyc(1'b0, 32'h0);

    begin_cyc(); end_cyc(1'b1);
    done = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL monitor_stall got no summary want summary");
    $fatal(1);
  end
endmodule
